// File: rtl/cvita_hdr_framer.sv
// CVITA framer: emits a header word, an optional VITA time word, then the payload stream.
// Generates the length field and the 12-bit sequence number; optional 2-deep output register.
module cvita_hdr_framer #(
   parameter int USE_SEQNUM_IN = 0,
   parameter int OUT_REG       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [1:0]  i_hdr_pkt_type,
   input  logic        i_hdr_eob,
   input  logic        i_hdr_has_time,
   input  logic [11:0] i_hdr_seqnum,
   input  logic [15:0] i_hdr_payload_length,
   input  logic [15:0] i_hdr_src_sid,
   input  logic [15:0] i_hdr_dst_sid,
   input  logic [63:0] i_hdr_vita_time,
   input  logic        i_hdr_tvalid,
   output logic        i_hdr_tready,
   input  logic [63:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [63:0] o_tdata,
   output logic        o_tlast,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic        len_err,
   output logic [1:0]  dbg_state_o
);

   // Every channel transfers exactly on a cycle where valid and ready are both high; a source
   // never drops valid or changes data while waiting, and valid never depends on ready.

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HDR     = 2'd1;
   localparam logic [1:0] ST_TIME    = 2'd2;
   localparam logic [1:0] ST_PAYLOAD = 2'd3;

   logic        rst;
   logic [1:0]  state_q, state_d;
   logic [1:0]  pkt_type_q;
   logic        eob_q, has_time_q;
   logic [11:0] seqnum_q, seq_cnt_q, hdr_seq;
   logic [15:0] length_q, src_sid_q, dst_sid_q;
   logic [63:0] vita_time_q;
   logic [13:0] beats_q;
   logic [15:0] beat_cnt_q;
   logic        len_err_q;
   logic [16:0] plen_rnd;
   logic        hdr_accept, pay_fire, hdr_fire;

   logic        pre_tvalid, pre_tready, pre_tlast;
   logic [63:0] pre_tdata;

   assign rst          = reset | clear;
   assign i_hdr_tready = (state_q == ST_IDLE);
   assign hdr_accept   = i_hdr_tvalid & i_hdr_tready;
   assign pay_fire     = i_tvalid & i_tready;
   assign hdr_fire     = (state_q == ST_HDR) & pre_tready;
   assign plen_rnd     = {1'b0, i_hdr_payload_length} + 17'd7;
   assign hdr_seq      = (USE_SEQNUM_IN != 0) ? i_hdr_seqnum : seq_cnt_q;
   assign len_err      = len_err_q;
   assign dbg_state_o  = state_q;

   always_comb begin
      state_d    = state_q;
      pre_tvalid = 1'b0;
      pre_tdata  = '0;
      pre_tlast  = 1'b0;
      i_tready   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_hdr_tvalid) state_d = ST_HDR;
         end
         ST_HDR: begin
            pre_tvalid = 1'b1;
            pre_tdata  = {pkt_type_q, has_time_q, eob_q, seqnum_q, length_q, src_sid_q, dst_sid_q};
            pre_tlast  = ~has_time_q & (beats_q == '0);
            if (pre_tready) begin
               if (has_time_q)          state_d = ST_TIME;
               else if (beats_q != '0)  state_d = ST_PAYLOAD;
               else                     state_d = ST_IDLE;
            end
         end
         ST_TIME: begin
            pre_tvalid = 1'b1;
            pre_tdata  = vita_time_q;
            pre_tlast  = (beats_q == '0);
            if (pre_tready) state_d = (beats_q != '0) ? ST_PAYLOAD : ST_IDLE;
         end
         ST_PAYLOAD: begin
            pre_tvalid = i_tvalid;
            pre_tdata  = i_tdata;
            pre_tlast  = i_tlast;
            i_tready   = pre_tready;
            if (i_tvalid & pre_tready & i_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pkt_type_q  <= '0;
         eob_q       <= 1'b0;
         has_time_q  <= 1'b0;
         seqnum_q    <= '0;
         seq_cnt_q   <= '0;
         length_q    <= '0;
         src_sid_q   <= '0;
         dst_sid_q   <= '0;
         vita_time_q <= '0;
         beats_q     <= '0;
         beat_cnt_q  <= '0;
         len_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_err_q <= 1'b0;
         if (hdr_accept) begin
            pkt_type_q  <= i_hdr_pkt_type;
            eob_q       <= i_hdr_eob;
            has_time_q  <= i_hdr_has_time;
            seqnum_q    <= hdr_seq;
            length_q    <= i_hdr_payload_length + (i_hdr_has_time ? 16'd16 : 16'd8);
            src_sid_q   <= i_hdr_src_sid;
            dst_sid_q   <= i_hdr_dst_sid;
            vita_time_q <= i_hdr_vita_time;
            beats_q     <= plen_rnd[16:3];
            beat_cnt_q  <= '0;
         end
         if (hdr_fire) seq_cnt_q <= seq_cnt_q + 12'd1;
         // The beat count compared includes the terminating beat itself.
         if (pay_fire) begin
            if (i_tlast) begin
               beat_cnt_q <= '0;
               len_err_q  <= ((beat_cnt_q + 16'd1) != {2'b00, beats_q});
            end else begin
               beat_cnt_q <= beat_cnt_q + 16'd1;
            end
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [64:0] buf_q [2];
      logic        wr_ptr_q, rd_ptr_q;
      logic [1:0]  count_q;
      logic        push, pop;

      assign pre_tready        = (count_q != 2'd2);
      assign push              = pre_tvalid & pre_tready;
      assign pop               = (count_q != 2'd0) & o_tready;
      assign o_tvalid          = (count_q != 2'd0);
      assign {o_tlast, o_tdata} = buf_q[rd_ptr_q];

      always_ff @(posedge clk) begin
         if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
         end else begin
            if (push) begin
               buf_q[wr_ptr_q] <= {pre_tlast, pre_tdata};
               wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
         end
      end
   end else begin : g_out_comb
      assign pre_tready = o_tready;
      assign o_tvalid   = pre_tvalid;
      assign o_tdata    = pre_tdata;
      assign o_tlast    = pre_tlast;
   end

endmodule

// File: tb/tb_cvita_hdr_framer.sv
// Bench for cvita_hdr_framer: directed packets plus randomized traffic against a packet-level
// model that predicts every output word (header, time, payload) and every length-error pulse.
module tb_cvita_hdr_framer;

   logic        clk = 1'b0;
   logic        reset, clear;
   logic [1:0]  i_hdr_pkt_type;
   logic        i_hdr_eob, i_hdr_has_time;
   logic [11:0] i_hdr_seqnum;
   logic [15:0] i_hdr_payload_length, i_hdr_src_sid, i_hdr_dst_sid;
   logic [63:0] i_hdr_vita_time;
   logic        i_hdr_tvalid, i_hdr_tready;
   logic [63:0] i_tdata;
   logic        i_tlast, i_tvalid, i_tready;
   logic [63:0] o_tdata;
   logic        o_tlast, o_tvalid, o_tready;
   logic        len_err;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   cvita_hdr_framer #(.USE_SEQNUM_IN(0), .OUT_REG(1)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .i_hdr_pkt_type(i_hdr_pkt_type), .i_hdr_eob(i_hdr_eob), .i_hdr_has_time(i_hdr_has_time),
      .i_hdr_seqnum(i_hdr_seqnum), .i_hdr_payload_length(i_hdr_payload_length),
      .i_hdr_src_sid(i_hdr_src_sid), .i_hdr_dst_sid(i_hdr_dst_sid),
      .i_hdr_vita_time(i_hdr_vita_time), .i_hdr_tvalid(i_hdr_tvalid), .i_hdr_tready(i_hdr_tready),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .len_err(len_err), .dbg_state_o(dbg_state)
   );

   typedef struct {
      logic [1:0]  pkt_type;
      logic        eob;
      logic        has_time;
      logic [15:0] plen;
      logic [15:0] src;
      logic [15:0] dst;
      logic [63:0] vtime;
   } pkt_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [64:0] exp_q[$];
   logic [64:0] pay_drv_q[$];
   int          tb_seq = 0;
   int          exp_len_err = 0;
   int          seen_len_err = 0;
   bit          rand_ready = 1'b0;
   bit          rand_gaps = 1'b0;

   task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_hdr(input pkt_t p, input int seq);
      int          len_bytes;
      logic [15:0] len16;
      logic [11:0] seq12;
      len_bytes = int'(p.plen) + (p.has_time ? 16 : 8);
      len16     = 16'(len_bytes % 65536);
      seq12     = 12'(seq % 4096);
      return {p.pkt_type, p.has_time, p.eob, seq12, len16, p.src, p.dst};
   endfunction

   // Queue the words this packet must produce and the beats to be driven.
   task automatic prep_pkt(input pkt_t p, input int n_actual);
      int          nb;
      logic [63:0] d;
      logic        last;
      nb = (int'(p.plen) + 7) / 8;
      exp_q.push_back({(!p.has_time && nb == 0), model_hdr(p, tb_seq)});
      tb_seq = (tb_seq + 1) % 4096;
      if (p.has_time) exp_q.push_back({(nb == 0), p.vtime});
      for (int i = 0; i < n_actual; i++) begin
         d    = {$urandom, $urandom};
         last = (i == n_actual - 1);
         exp_q.push_back({last, d});
         pay_drv_q.push_back({last, d});
      end
      if (n_actual != nb) exp_len_err++;
   endtask

   task automatic send_hdr(input pkt_t p);
      bit acc;
      int w;
      if (rand_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      i_hdr_pkt_type       = p.pkt_type;
      i_hdr_eob            = p.eob;
      i_hdr_has_time       = p.has_time;
      i_hdr_payload_length = p.plen;
      i_hdr_src_sid        = p.src;
      i_hdr_dst_sid        = p.dst;
      i_hdr_vita_time      = p.vtime;
      i_hdr_seqnum         = 12'($urandom);
      i_hdr_tvalid         = 1'b1;
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 500) begin
         @(negedge clk);
         acc = i_hdr_tready;
         @(posedge clk); #1;
         w++;
      end
      i_hdr_tvalid = 1'b0;
      if (!acc) chk("hdr_timeout", 65'(acc), 65'd1);
   endtask

   task automatic send_beat(input logic [64:0] b);
      bit acc;
      int w;
      if (rand_gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) begin
         @(posedge clk); #1;
      end
      {i_tlast, i_tdata} = b;
      i_tvalid = 1'b1;
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 500) begin
         @(negedge clk);
         acc = i_tready;
         @(posedge clk); #1;
         w++;
      end
      i_tvalid = 1'b0;
      if (!acc) chk("beat_timeout", 65'(acc), 65'd1);
   endtask

   task automatic send_payload();
      while (pay_drv_q.size() != 0) send_beat(pay_drv_q.pop_front());
   endtask

   task automatic run_pkt(input pkt_t p, input int n_actual);
      prep_pkt(p, n_actual);
      fork
         send_hdr(p);
         send_payload();
      join
   endtask

   function automatic pkt_t rand_pkt(input int max_plen);
      pkt_t p;
      p.pkt_type = 2'($urandom_range(0, 3));
      p.eob      = 1'($urandom_range(0, 1));
      p.has_time = 1'($urandom_range(0, 1));
      p.plen     = 16'($urandom_range(0, max_plen));
      p.src      = 16'($urandom);
      p.dst      = 16'($urandom);
      p.vtime    = {$urandom, $urandom};
      return p;
   endfunction

   initial begin
      o_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output scoreboard, stall-stability and len_err pulse monitor.
   logic [64:0] prev_word;
   bit          prev_stall = 1'b0;
   bit          prev_len_err = 1'b0;
   always @(negedge clk) begin
      if (reset || clear) begin
         prev_stall   = 1'b0;
         prev_len_err = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 65'(o_tvalid), 65'd1);
            chk("stall_word", {o_tlast, o_tdata}, prev_word);
         end
         if (o_tvalid && o_tready) begin
            if (exp_q.size() == 0) chk("unexpected_word", {o_tlast, o_tdata}, 65'h0);
            else chk("word", {o_tlast, o_tdata}, exp_q.pop_front());
         end
         prev_stall = o_tvalid && !o_tready;
         prev_word  = {o_tlast, o_tdata};
         if (len_err) begin
            seen_len_err++;
            chk("len_err_pulse", 65'(prev_len_err), 65'd0);
         end
         prev_len_err = len_err;
      end
   end

   initial begin
      pkt_t p;
      bit   seen;
      int   nb, na, w;

      reset = 1'b1; clear = 1'b0;
      i_hdr_tvalid = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
      i_hdr_pkt_type = '0; i_hdr_eob = 1'b0; i_hdr_has_time = 1'b0; i_hdr_seqnum = '0;
      i_hdr_payload_length = '0; i_hdr_src_sid = '0; i_hdr_dst_sid = '0; i_hdr_vita_time = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_hdr_tready", 65'(i_hdr_tready), 65'd1);
      chk("rst_i_tready", 65'(i_tready), 65'd0);
      chk("rst_o_tvalid", 65'(o_tvalid), 65'd0);
      chk("rst_len_err", 65'(len_err), 65'd0);
      @(posedge clk); #1;

      // 1: three-beat packets, header latency, seqnum 0 then 1
      p = '{pkt_type: 2'd0, eob: 1'b0, has_time: 1'b0, plen: 16'd24,
            src: 16'h0010, dst: 16'h0020, vtime: 64'h0};
      prep_pkt(p, 3);
      fork
         begin
            send_hdr(p);
            @(negedge clk);
            chk("t1_latency_early", 65'(o_tvalid), 65'd0);
            @(negedge clk);
            chk("t1_hdr", {o_tvalid, o_tdata}, {1'b1, 64'h0000_0020_0010_0020});
         end
         send_payload();
      join
      run_pkt(p, 3);
      repeat (4) @(posedge clk); #1;
      chk("t1_no_len_err", 65'(seen_len_err), 65'd0);

      // 2: time word, eob, single beat
      p = '{pkt_type: 2'd0, eob: 1'b1, has_time: 1'b1, plen: 16'd8,
            src: 16'h0abc, dst: 16'h0def, vtime: 64'h1122334455667788};
      run_pkt(p, 1);

      // 3: empty payload, header alone carries tlast
      p = '{pkt_type: 2'd1, eob: 1'b0, has_time: 1'b0, plen: 16'd0,
            src: 16'h1234, dst: 16'h5678, vtime: 64'h0};
      prep_pkt(p, 0);
      fork
         send_hdr(p);
         begin
            seen = 1'b0;
            repeat (6) begin @(negedge clk); seen |= i_tready; end
            chk("t3_i_tready_never", 65'(seen), 65'd0);
         end
      join
      @(posedge clk); #1;

      // 5: declared 32 bytes, tlast on beat 2
      p = '{pkt_type: 2'd0, eob: 1'b0, has_time: 1'b0, plen: 16'd32,
            src: 16'h0001, dst: 16'h0002, vtime: 64'h0};
      run_pkt(p, 2);
      @(negedge clk);
      chk("t5_len_err_high", 65'(len_err), 65'd1);
      @(negedge clk);
      chk("t5_len_err_low", 65'(len_err), 65'd0);
      @(posedge clk); #1;

      // Length field wraps mod 2^16; short packet also flags len_err
      p = '{pkt_type: 2'd2, eob: 1'b0, has_time: 1'b1, plen: 16'd65530,
            src: 16'hbeef, dst: 16'hcafe, vtime: 64'hdead_0000_0000_0001};
      run_pkt(p, 1);

      // 4: random traffic with stalls, gaps and occasional length mismatches
      rand_ready = 1'b1;
      rand_gaps  = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         p  = rand_pkt(48);
         nb = (int'(p.plen) + 7) / 8;
         na = nb;
         if (nb != 0 && $urandom_range(0, 9) == 0) begin
            na = $urandom_range(1, nb + 2);
            if (na == nb) na = nb + 1;
         end
         run_pkt(p, na);
      end

      // Short packets to carry the sequence number through 4095 -> 0
      rand_ready = 1'b0;
      rand_gaps  = 1'b0;
      repeat (4096 - tb_seq + 5) begin
         p = rand_pkt(0);
         run_pkt(p, 0);
      end
      repeat (6) @(posedge clk); #1;

      // 6: clear during the second payload beat
      p = '{pkt_type: 2'd0, eob: 1'b0, has_time: 1'b0, plen: 16'd32,
            src: 16'h00aa, dst: 16'h00bb, vtime: 64'h0};
      prep_pkt(p, 4);
      fork
         send_hdr(p);
         begin
            send_beat(pay_drv_q.pop_front());
            send_beat(pay_drv_q.pop_front());
         end
      join
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      exp_q.delete();
      pay_drv_q.delete();
      tb_seq = 0;
      @(negedge clk);
      chk("t6_o_tvalid_cleared", 65'(o_tvalid), 65'd0);
      chk("t6_hdr_tready", 65'(i_hdr_tready), 65'd1);
      @(posedge clk); #1;
      p = '{pkt_type: 2'd3, eob: 1'b1, has_time: 1'b0, plen: 16'd16,
            src: 16'h0f0f, dst: 16'hf0f0, vtime: 64'h0};
      run_pkt(p, 2);

      w = 0;
      while (exp_q.size() != 0 && w < 200) begin @(negedge clk); w++; end
      chk("drain", 65'(exp_q.size()), 65'd0);
      repeat (3) @(posedge clk);
      chk("len_err_count", 65'(seen_len_err), 65'(exp_len_err));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
